// File: rtl/noc_result_receiver.sv
// -----------------------------------------------------------------------------
// noc_result_receiver
//
// Ejection-side AXI-Stream endpoint of the NoC adder datapath. It takes result
// packets from the local mesh router port, checks that each packet is well
// formed and addressed to this node, and adds up the payload flits. A good
// packet updates DATA_O and raises a one-cycle DONE pulse. A packet that is
// malformed or addressed elsewhere is drained to its TLAST and then raises a
// one-cycle ERR pulse.
//
// Header flit: [TDATAW-1:TDATAW-8] = sequence number, [7:0] = payload count N.
//
// Optional feature (compile-time macro RX_SEQ_CHECK_EN):
//   defined   - each good packet's header seq is compared with an expected-seq
//               register. A mismatch pulses SEQ_ERR in the DONE cycle, and the
//               packet is still delivered.
//   undefined - SEQ_ERR is tied low and the seq field is ignored.
//
// Ports:
//   CLK       in   1       rising-edge clock
//   RST_N     in   1       asynchronous active-low reset
//   S_TVALID  in   1       flit valid from router ejection port
//   S_TREADY  out  1       flit accept (registered; never depends on S_TVALID)
//   S_TDATA   in   TDATAW  flit data
//   S_TDEST   in   DESTW   destination node (checked on header flit)
//   S_TLAST   in   1       last flit of packet
//   DONE      out  1       1-cycle pulse: good packet complete, DATA_O updated
//   DATA_O    out  TDATAW  payload sum of last good packet (held)
//   ERR       out  1       1-cycle pulse: bad packet dropped
//   SEQ_ERR   out  1       1-cycle pulse: sequence gap (RX_SEQ_CHECK_EN only)
//   PKT_CNT   out  16      good packet count, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module noc_result_receiver #(
   parameter int TDATAW    = 32,
   parameter int DESTW     = 4,
   parameter int NODE_ID   = 0,
   parameter int MAX_FLITS = 4
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              S_TVALID,
   output logic              S_TREADY,
   input  logic [TDATAW-1:0] S_TDATA,
   input  logic [DESTW-1:0]  S_TDEST,
   input  logic              S_TLAST,
   output logic              DONE,
   output logic [TDATAW-1:0] DATA_O,
   output logic              ERR,
   output logic              SEQ_ERR,
   output logic [15:0]       PKT_CNT
);

   localparam logic [7:0]       MAX_N   = 8'(MAX_FLITS);
   localparam logic [DESTW-1:0] MY_DEST = DESTW'(NODE_ID);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PAYLOAD,
      ST_DROP,
      ST_DELIVER,
      ST_ERR_OUT
   } state_t;

   state_t            state, next_state;
   logic [TDATAW-1:0] acc;
   logic [TDATAW-1:0] acc_sum;
   logic [7:0]        remaining;
   logic [7:0]        hdr_n;
   logic              xfer;
   logic              hdr_bad;
   logic              load_hdr;
   logic              accumulate;
   logic              deliver_go;

   assign xfer    = S_TVALID && S_TREADY;
   assign hdr_n   = S_TDATA[7:0];
   assign hdr_bad = (S_TDEST != MY_DEST) || (hdr_n == 8'd0) || (hdr_n > MAX_N);
   // Carry out of the top bit is discarded on purpose: the sum wraps mod 2^TDATAW.
   assign acc_sum = acc + S_TDATA;

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and datapath control.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can leave a value held and infer a latch.
      next_state = state;
      load_hdr   = 1'b0;
      accumulate = 1'b0;
      deliver_go = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (xfer) begin
               if (hdr_bad) begin
                  // A single-flit bad header already carries TLAST: nothing left to drain.
                  next_state = S_TLAST ? ST_ERR_OUT : ST_DROP;
               end else if (S_TLAST) begin
                  // Header claims N payload flits but the packet has none.
                  next_state = ST_ERR_OUT;
               end else begin
                  next_state = ST_PAYLOAD;
                  load_hdr   = 1'b1;
               end
            end
         end
         ST_PAYLOAD: begin
            if (xfer) begin
               accumulate = 1'b1;
               if (S_TLAST) begin
                  if (remaining == 8'd1) begin
                     next_state = ST_DELIVER;
                     deliver_go = 1'b1;
                  end else begin
                     next_state = ST_ERR_OUT;   // packet ended early
                  end
               end else if (remaining == 8'd1) begin
                  next_state = ST_DROP;         // more flits than announced
               end
            end
         end
         ST_DROP: begin
            if (xfer && S_TLAST) begin
               next_state = ST_ERR_OUT;
            end
         end
         ST_DELIVER: next_state = ST_IDLE;
         ST_ERR_OUT: next_state = ST_IDLE;
         default:    next_state = ST_IDLE;
      endcase
   end

   // Datapath and registered outputs. The outputs are loaded from next_state,
   // so DONE/ERR/S_TREADY line up with the DELIVER/ERR_OUT/accepting states.
   // DATA_O and PKT_CNT are loaded on the final flit handshake, so they are
   // already valid in the DONE cycle.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         acc       <= '0;
         remaining <= '0;
         DATA_O    <= '0;
         PKT_CNT   <= '0;
         S_TREADY  <= 1'b0;
         DONE      <= 1'b0;
         ERR       <= 1'b0;
      end else begin
         S_TREADY <= (next_state == ST_IDLE) || (next_state == ST_PAYLOAD) ||
                     (next_state == ST_DROP);
         DONE     <= (next_state == ST_DELIVER);
         ERR      <= (next_state == ST_ERR_OUT);

         if (load_hdr) begin
            acc       <= '0;
            remaining <= hdr_n;
         end else if (accumulate) begin
            acc       <= acc_sum;
            remaining <= remaining - 8'd1;
         end

         if (deliver_go) begin
            DATA_O <= acc_sum;
            if (PKT_CNT != 16'hFFFF) begin
               PKT_CNT <= PKT_CNT + 16'd1;
            end
         end
      end
   end

`ifdef RX_SEQ_CHECK_EN
   logic [7:0] exp_seq;
   logic [7:0] pkt_seq;
   logic       seq_err_q;

   // The header seq is captured when the header is accepted. It is judged only
   // at delivery, so dropped packets never advance the expected sequence.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         exp_seq   <= '0;
         pkt_seq   <= '0;
         seq_err_q <= 1'b0;
      end else begin
         seq_err_q <= 1'b0;
         if (load_hdr) begin
            pkt_seq <= S_TDATA[TDATAW-1 -: 8];
         end
         if (deliver_go) begin
            seq_err_q <= (pkt_seq != exp_seq);
            exp_seq   <= pkt_seq + 8'd1;
         end
      end
   end

   assign SEQ_ERR = seq_err_q;
`else
   assign SEQ_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_noc_result_receiver.sv
// -----------------------------------------------------------------------------
// tb_noc_result_receiver
//
// Directed self-checking bench for noc_result_receiver (default parameters:
// TDATAW=32, DESTW=4, NODE_ID=0, MAX_FLITS=4). Expected values are hand-
// computed. The expected SEQ_ERR comes from a small expected-seq model that
// follows the RX_SEQ_CHECK_EN macro.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_noc_result_receiver;

   logic        CLK;
   logic        RST_N;
   logic        S_TVALID;
   logic        S_TREADY;
   logic [31:0] S_TDATA;
   logic [3:0]  S_TDEST;
   logic        S_TLAST;
   logic        DONE;
   logic [31:0] DATA_O;
   logic        ERR;
   logic        SEQ_ERR;
   logic [15:0] PKT_CNT;

   int         n_cmp  = 0;
   int         n_fail = 0;
   logic [7:0] model_seq = 8'd0;

`ifdef RX_SEQ_CHECK_EN
   localparam bit SEQ_CHECK = 1'b1;
`else
   localparam bit SEQ_CHECK = 1'b0;
`endif

   noc_result_receiver dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .S_TVALID (S_TVALID),
      .S_TREADY (S_TREADY),
      .S_TDATA  (S_TDATA),
      .S_TDEST  (S_TDEST),
      .S_TLAST  (S_TLAST),
      .DONE     (DONE),
      .DATA_O   (DATA_O),
      .ERR      (ERR),
      .SEQ_ERR  (SEQ_ERR),
      .PKT_CNT  (PKT_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_cmp++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Called at a falling edge. It drives one flit, waits (bounded) for
   // S_TREADY, lets the handshake edge pass and returns at the next falling
   // edge with S_TVALID low.
   task automatic send_flit(input logic [31:0] d, input logic [3:0] dst, input logic last);
      int waits = 0;
      S_TVALID = 1'b1;
      S_TDATA  = d;
      S_TDEST  = dst;
      S_TLAST  = last;
      while (S_TREADY !== 1'b1 && waits < 20) begin
         @(negedge CLK);
         waits++;
      end
      n_cmp++;
      assert (waits < 20)
      else begin
         n_fail++;
         $error("FAIL tready_timeout: observed waits %0d expected < 20", waits);
      end
      @(posedge CLK);
      @(negedge CLK);
      S_TVALID = 1'b0;
      S_TLAST  = 1'b0;
   endtask

   // Header plus nflits payload flits; TLAST goes on the last flit (on the
   // header itself when nflits==0). With gaps set, one idle cycle carrying
   // junk data is inserted between flits.
   task automatic send_pkt(input logic [7:0] seq, input logic [3:0] dst, input logic [7:0] n,
                           input int nflits, input bit gaps,
                           input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                           input logic [31:0] p3, input logic [31:0] p4);
      logic [31:0] pl [5];
      pl[0] = p0; pl[1] = p1; pl[2] = p2; pl[3] = p3; pl[4] = p4;
      send_flit({seq, 16'h0000, n}, dst, nflits == 0);
      for (int i = 0; i < nflits; i++) begin
         if (gaps) begin
            S_TDATA = 32'hDEAD_BEEF;
            S_TLAST = 1'b1;
            @(negedge CLK);
            S_TLAST = 1'b0;
         end
         send_flit(pl[i], dst, i == nflits - 1);
      end
   endtask

   // Checks made in the cycle after a good packet's final flit, then one
   // cycle later to confirm the pulse lasts exactly one cycle.
   task automatic expect_done(input string tag, input logic [7:0] seq,
                              input logic [31:0] data, input logic [15:0] cnt);
      logic exp_seq_err;
      exp_seq_err = SEQ_CHECK && (seq != model_seq);
      model_seq   = seq + 8'd1;
      check({tag, ".done"},    32'(DONE),    32'd1);
      check({tag, ".err"},     32'(ERR),     32'd0);
      check({tag, ".data"},    DATA_O,       data);
      check({tag, ".cnt"},     32'(PKT_CNT), 32'(cnt));
      check({tag, ".seq_err"}, 32'(SEQ_ERR), 32'(exp_seq_err));
      check({tag, ".tready"},  32'(S_TREADY), 32'd0);
      @(negedge CLK);
      check({tag, ".done_end"}, 32'(DONE), 32'd0);
   endtask

   task automatic expect_err(input string tag, input logic [31:0] data, input logic [15:0] cnt);
      check({tag, ".err"},     32'(ERR),     32'd1);
      check({tag, ".done"},    32'(DONE),    32'd0);
      check({tag, ".data"},    DATA_O,       data);
      check({tag, ".cnt"},     32'(PKT_CNT), 32'(cnt));
      check({tag, ".seq_err"}, 32'(SEQ_ERR), 32'd0);
      @(negedge CLK);
      check({tag, ".err_end"}, 32'(ERR), 32'd0);
   endtask

   initial begin
      RST_N    = 1'b0;
      S_TVALID = 1'b0;
      S_TDATA  = '0;
      S_TDEST  = '0;
      S_TLAST  = 1'b0;
      repeat (3) @(negedge CLK);

      // Reset state.
      check("rst.tready",  32'(S_TREADY), 32'd0);
      check("rst.done",    32'(DONE),     32'd0);
      check("rst.data",    DATA_O,        32'd0);
      check("rst.err",     32'(ERR),      32'd0);
      check("rst.seq_err", 32'(SEQ_ERR),  32'd0);
      check("rst.cnt",     32'(PKT_CNT),  32'd0);
      RST_N = 1'b1;

      // 1: basic sum 5 + 7.
      send_pkt(8'd0, 4'd0, 8'd2, 2, 1'b0, 32'h5, 32'h7, 0, 0, 0);
      expect_done("t1", 8'd0, 32'h0000_000C, 16'd1);

      // 2: wrap-around sum, then the same packet with S_TVALID gaps.
      send_pkt(8'd1, 4'd0, 8'd2, 2, 1'b0, 32'hFFFF_FFFF, 32'h2, 0, 0, 0);
      expect_done("t2", 8'd1, 32'h0000_0001, 16'd2);
      send_pkt(8'd2, 4'd0, 8'd2, 2, 1'b1, 32'hFFFF_FFFF, 32'h2, 0, 0, 0);
      expect_done("t2g", 8'd2, 32'h0000_0001, 16'd3);

      // 3: misrouted packet, 3 flits all accepted, ERR once.
      send_pkt(8'd3, 4'd1, 8'd2, 2, 1'b0, 32'h100, 32'h200, 0, 0, 0);
      expect_err("t3", 32'h0000_0001, 16'd3);

      // 4: early TLAST, oversize N, TLAST on header, late TLAST.
      send_pkt(8'd3, 4'd0, 8'd3, 2, 1'b0, 32'h1, 32'h2, 0, 0, 0);
      expect_err("t4early", 32'h0000_0001, 16'd3);
      send_pkt(8'd3, 4'd0, 8'd5, 2, 1'b0, 32'h1, 32'h2, 0, 0, 0);
      expect_err("t4big", 32'h0000_0001, 16'd3);
      send_pkt(8'd3, 4'd0, 8'd2, 0, 1'b0, 0, 0, 0, 0, 0);
      expect_err("t4hdrlast", 32'h0000_0001, 16'd3);
      send_pkt(8'd3, 4'd0, 8'd1, 2, 1'b0, 32'h9, 32'h9, 0, 0, 0);
      expect_err("t4late", 32'h0000_0001, 16'd3);
      send_pkt(8'd3, 4'd0, 8'd0, 1, 1'b0, 32'h9, 0, 0, 0, 0);
      expect_err("t4zero", 32'h0000_0001, 16'd3);

      // 5: seqs 3, 4, 6 -> only the last one is out of sequence.
      send_pkt(8'd3, 4'd0, 8'd1, 1, 1'b0, 32'h0A, 0, 0, 0, 0);
      expect_done("t5a", 8'd3, 32'h0000_000A, 16'd4);
      send_pkt(8'd4, 4'd0, 8'd1, 1, 1'b0, 32'h14, 0, 0, 0, 0);
      expect_done("t5b", 8'd4, 32'h0000_0014, 16'd5);
      send_pkt(8'd6, 4'd0, 8'd1, 1, 1'b0, 32'h1E, 0, 0, 0, 0);
      expect_done("t5c", 8'd6, 32'h0000_001E, 16'd6);

      // Boundary: N == MAX_FLITS is accepted.
      send_pkt(8'd7, 4'd0, 8'd4, 4, 1'b0, 32'h1, 32'h2, 32'h3, 32'h4, 0);
      expect_done("tmax", 8'd7, 32'h0000_000A, 16'd7);

      // 6: reset mid-payload, then a clean packet.
      send_flit({8'd8, 16'h0000, 8'd3}, 4'd0, 1'b0);
      send_flit(32'h1234, 4'd0, 1'b0);
      RST_N = 1'b0;
      #1;
      check("t6.tready",  32'(S_TREADY), 32'd0);
      check("t6.done",    32'(DONE),     32'd0);
      check("t6.data",    DATA_O,        32'd0);
      check("t6.err",     32'(ERR),      32'd0);
      check("t6.seq_err", 32'(SEQ_ERR),  32'd0);
      check("t6.cnt",     32'(PKT_CNT),  32'd0);
      @(negedge CLK);
      RST_N     = 1'b1;
      model_seq = 8'd0;
      send_pkt(8'd0, 4'd0, 8'd1, 1, 1'b0, 32'h55, 0, 0, 0, 0);
      expect_done("t6post", 8'd0, 32'h0000_0055, 16'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
